mult_share_arbiter: RTL and testbench

//  Shares one Q8.8 signed fixed-point multiplier (`multiplier`: rounded
//  (a*b + 2^7) >>> 8, low 16 bits kept) between N_REQ ODE-solver requesters.
//  - Round-robin arbitration and valid/ready handshake per requester.
//  - 2-stage pipeline: operand register, then result register.
//  - Each result is tagged with the requester id.
//  - Sits between the solver step engines and the single multiplier instance.

---
 rtl/mult_share_pkg.sv | 25 ++
 rtl/mult_share_arbiter_if.sv | 28 ++
 rtl/mult_share_arbiter_rr_arbiter.sv | 28 ++
 rtl/multiplier.sv | 11 +
 rtl/mult_share_arbiter.sv | 77 +++++++
 tb/tb_mult_share_arbiter.sv | 201 ++++++++++++++++++++
 6 files changed

// File: rtl/mult_share_pkg.sv
// Q8.8 constants, requester defaults and the operand-stage record shared by the multiplier arbiter.
// The product helper is the single definition of the rounded, wrapping Q8.8 multiply.
package mult_share_pkg;

    localparam int DATA_W    = 16;
    localparam int FRAC_W    = 8;
    localparam logic signed [31:0] ROUND_BIAS = 32'sh80;
    localparam int N_REQ_DEF = 4;
    localparam int MAX_ID_W  = 3;

    // id is sized for the largest supported requester count; narrower configs zero-extend
    typedef struct packed {
        logic [DATA_W-1:0]   a;
        logic [DATA_W-1:0]   b;
        logic [MAX_ID_W-1:0] id;
    } stage_t;

    function automatic logic [DATA_W-1:0] q88_mul(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic signed [31:0] prod;
        prod = 32'($signed(a)) * 32'($signed(b)) + ROUND_BIAS;
        return DATA_W'(prod >>> FRAC_W);
    endfunction

endpackage

// File: rtl/mult_share_arbiter_if.sv
// Requester/consumer bundle for the shared multiplier: per-requester valid/ready plus one response channel.
// master = requesters and consumer side, slave = arbiter side.
interface mult_share_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 16,
    parameter int ID_W   = 2
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_a;
    logic [N_REQ*DATA_W-1:0] req_b;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DATA_W-1:0]       rsp_data;
    logic [ID_W-1:0]         rsp_id;
    logic                    busy;
    logic [15:0]             op_count;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id, busy, op_count
    );
endinterface

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Round-robin grant: search starts one past rr_ptr, first active request wins.
// Purely combinational; grant is one-hot or zero.
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);
    always_comb begin
        logic            found;
        logic [ID_W-1:0] cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(rr_ptr) + k) % N_REQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end
endmodule

// File: rtl/multiplier.sv
// Combinational Q8.8 signed multiply: (a*b + 0x80) >>> 8, low 16 bits, wraps on overflow.
// Zero latency; no flow control.
module multiplier
    import mult_share_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] p
);
    assign p = q88_mul(a, b);
endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one Q8.8 multiplier among N_REQ requesters; 2-cycle latency, 1 op/cycle, id-tagged results.
// A stalled response holds both stages; req_ready drops only while s1 is full and cannot advance.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    mult_share_arbiter_if.slave bus
);
    logic [N_REQ-1:0]    grant;
    logic [N_REQ-1:0]    req_ready;
    logic [ID_W-1:0]     grant_idx;
    logic [ID_W-1:0]     rr_ptr;
    logic                adv1, adv2, accept;
    stage_t              s1;
    logic                s1_valid, s2_valid;
    logic [DATA_W-1:0]   s2_data, mul_p;
    logic [MAX_ID_W-1:0] s2_id;
    logic [15:0]         op_count;

    rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
        .req      (bus.req_valid),
        .rr_ptr   (rr_ptr),
        .grant    (grant),
        .grant_idx(grant_idx)
    );

    multiplier u_mul (
        .a(s1.a),
        .b(s1.b),
        .p(mul_p)
    );

    assign adv2      = !s2_valid || bus.rsp_ready;
    assign adv1      = !s1_valid || adv2;
    assign req_ready = grant & {N_REQ{adv1}};
    assign accept    = |req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
            s1       <= '0;
            s2_data  <= '0;
            s2_id    <= '0;
            rr_ptr   <= ID_W'(N_REQ - 1);
            op_count <= '0;
        end else begin
            if (adv1) s1_valid <= accept;
            if (accept) begin
                s1.a     <= bus.req_a[int'(grant_idx)*DATA_W +: DATA_W];
                s1.b     <= bus.req_b[int'(grant_idx)*DATA_W +: DATA_W];
                s1.id    <= MAX_ID_W'(grant_idx);
                rr_ptr   <= grant_idx;
                op_count <= op_count + 16'd1;
            end
            // result registers only load real data so they keep the last value while idle
            if (adv2) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_data <= mul_p;
                    s2_id   <= s1.id;
                end
            end
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = s2_valid;
    assign bus.rsp_data  = s2_data;
    assign bus.rsp_id    = ID_W'(s2_id);
    assign bus.busy      = s1_valid || s2_valid;
    assign bus.op_count  = op_count;
endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed bench for mult_share_arbiter: single op, rounding, fairness, backpressure, reset, idle grant.
module tb_mult_share_arbiter;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mult_share_arbiter_if #(.N_REQ(4), .DATA_W(16), .ID_W(2)) bus ();

    mult_share_arbiter #(.N_REQ(4), .ID_W(2)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
        bus.req_a[i*16 +: 16] = a;
        bus.req_b[i*16 +: 16] = b;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid = '0;
        bus.req_a = '0;
        bus.req_b = '0;
        bus.rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy); end
        checks++; if (bus.op_count !== 16'h0) begin errors++; $display("FAIL reset_op_count got %h want 0000", bus.op_count); end
        checks++; if (bus.rsp_data !== 16'h0) begin errors++; $display("FAIL reset_rsp_data got %h want 0000", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id got %0d want 0", bus.rsp_id); end
        rst = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", bus.req_ready); end
        @(negedge clk);
    endtask

    task automatic test_single();
        set_req(0, 16'h0180, 16'h0200);
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_ready got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %0b want 1", bus.busy); end
        checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL single_op_count got %0d want 1", bus.op_count); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %0b want 1", bus.rsp_valid); end
        checks++; if (bus.rsp_data !== 16'h0300) begin errors++; $display("FAIL single_data got %h want 0300", bus.rsp_data); end
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL single_id got %0d want 0", bus.rsp_id); end
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drain_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_drain_busy got %0b want 0", bus.busy); end
        checks++; if (bus.rsp_data !== 16'h0300) begin errors++; $display("FAIL single_hold_data got %h want 0300", bus.rsp_data); end
    endtask

    task automatic test_sign_round();
        logic [15:0] av [3] = '{16'hFF00, 16'h0001, 16'h7F00};
        logic [15:0] bv [3] = '{16'h0080, 16'h0080, 16'h0200};
        logic [15:0] ev [3] = '{16'hFF80, 16'h0001, 16'hFE00};
        for (int k = 0; k < 5; k++) begin
            if (k < 3) begin
                set_req(0, av[k], bv[k]);
                bus.req_valid = 4'b0001;
            end else begin
                bus.req_valid = 4'b0000;
            end
            @(negedge clk);
            if (k >= 1 && k <= 3) begin
                checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL sign_valid%0d got %0b want 1", k-1, bus.rsp_valid); end
                checks++; if (bus.rsp_data !== ev[k-1]) begin errors++; $display("FAIL sign_data%0d got %h want %h", k-1, bus.rsp_data, ev[k-1]); end
            end
        end
    endtask

    task automatic test_fairness();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'((i + 1) * 256), 16'h0100);
        bus.req_valid = 4'b1111;
        for (int k = 0; k <= 8; k++) begin
            if (k == 8) bus.req_valid = 4'b0000;
            #1;
            if (k < 8) begin
                checks++; if (bus.req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL fair_grant%0d got %b want %b", k, bus.req_ready, 4'(1 << (k % 4))); end
            end
            @(negedge clk);
            if (k >= 1) begin
                checks++; if (bus.rsp_id !== 2'((k - 1) % 4)) begin errors++; $display("FAIL fair_id%0d got %0d want %0d", k-1, bus.rsp_id, (k - 1) % 4); end
                checks++; if (bus.rsp_data !== 16'((((k - 1) % 4) + 1) * 256)) begin errors++; $display("FAIL fair_data%0d got %h want %h", k-1, bus.rsp_data, 16'((((k - 1) % 4) + 1) * 256)); end
            end
        end
        @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL fair_busy got %0b want 0", bus.busy); end
        checks++; if (bus.op_count !== 16'd8) begin errors++; $display("FAIL fair_op_count got %0d want 8", bus.op_count); end
    endtask

    task automatic test_backpressure();
        int sent = 0;
        int got  = 0;
        for (int k = 0; k < 12; k++) begin
            bus.rsp_ready = !(k >= 2 && k <= 4);
            if (sent < 5) begin
                set_req(2, 16'((sent + 1) * 256), 16'h0200);
                bus.req_valid = 4'b0100;
            end else begin
                bus.req_valid = 4'b0000;
            end
            #1;
            if (k >= 2 && k <= 4) begin
                checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_ready_stall%0d got %b want 0000", k, bus.req_ready); end
            end
            if (bus.rsp_valid) begin
                checks++; if (bus.rsp_id !== 2'd2) begin errors++; $display("FAIL bp_id%0d got %0d want 2", got, bus.rsp_id); end
                checks++; if (bus.rsp_data !== 16'((got + 1) * 512)) begin errors++; $display("FAIL bp_data%0d got %h want %h", got, bus.rsp_data, 16'((got + 1) * 512)); end
                if (bus.rsp_ready) got++;
            end
            if (bus.req_ready[2]) sent++;
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        checks++; if (got !== 5) begin errors++; $display("FAIL bp_received got %0d want 5", got); end
        checks++; if (sent !== 5) begin errors++; $display("FAIL bp_accepted got %0d want 5", sent); end
        checks++; if (bus.op_count !== 16'd13) begin errors++; $display("FAIL bp_op_count got %0d want 13", bus.op_count); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL bp_busy got %0b want 0", bus.busy); end
    endtask

    task automatic test_reset_midflight();
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 16'h0100, 16'h0100);
        bus.req_valid = 4'b0010;
        repeat (2) @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b1) begin errors++; $display("FAIL mid_full_valid got %0b want 1", bus.rsp_valid); end
        rst = 1'b1;
        bus.req_valid = 4'b1111;
        @(negedge clk);
        checks++; if (bus.rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %0b want 0", bus.rsp_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %0b want 0", bus.busy); end
        checks++; if (bus.op_count !== 16'd0) begin errors++; $display("FAIL mid_op_count got %0d want 0", bus.op_count); end
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant got %b want 0001", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        checks++; if (bus.rsp_id !== 2'd0) begin errors++; $display("FAIL mid_rsp_id got %0d want 0", bus.rsp_id); end
        checks++; if (bus.op_count !== 16'd1) begin errors++; $display("FAIL mid_op_count_after got %0d want 1", bus.op_count); end
        @(negedge clk);
    endtask

    task automatic test_idle_grant();
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b0001;
        repeat (2) @(negedge clk);
        bus.req_valid = 4'b0010;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_blocked1 got %b want 0000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1010;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL idle_blocked2 got %b want 0000", bus.req_ready); end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        #1;
        checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL idle_req1_grant got %b want 0010", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b1000;
        #1;
        checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL idle_req3_grant got %b want 1000", bus.req_ready); end
        @(negedge clk);
        bus.req_valid = 4'b0000;
        repeat (4) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %0b want 0", bus.busy); end
        checks++; if (bus.rsp_id !== 2'd3) begin errors++; $display("FAIL idle_last_id got %0d want 3", bus.rsp_id); end
        checks++; if (bus.op_count !== 16'd5) begin errors++; $display("FAIL idle_op_count got %0d want 5", bus.op_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sign_round();
        test_fairness();
        test_backpressure();
        test_reset_midflight();
        test_idle_grant();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d checks", checks);
        $fatal(1);
    end
endmodule
